// File: rtl/dsp_vector_unit_if.sv
// Operand/result bus for the fixed-point vector coprocessor.
interface dsp_vector_unit_if #(
  parameter int N     = 8,
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       operation;
  logic [WIDTH-1:0] A      [N-1:0];
  logic [WIDTH-1:0] B      [N-1:0];
  logic [WIDTH-1:0] result [N-1:0];
  logic             done;

  modport master (output start, operation, A, B, input result, done);
  modport slave  (input start, operation, A, B, output result, done);
endinterface

// File: rtl/dsp_vector_unit.sv
// Q16.16 vector coprocessor: element-wise add/mul/sub in one cycle, or an
// N-tap FIR window computed with one multiply-accumulate per cycle.
module dsp_vector_unit #(
  parameter int N     = 8,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic           clk,
  input  logic           rst,
  dsp_vector_unit_if.slave bus
);

  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = 2*WIDTH + 4;
  localparam logic signed [CW+1:0] HALF = (CW+2)'(N/2);

  typedef enum logic [1:0] {IDLE, CALC, FIR} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_MUL = 2'b01,
                            OP_FIR = 2'b10, OP_SUB = 2'b11} op_t;

  state_t                   state, state_nx;
  op_t                      op_r;
  logic signed [WIDTH-1:0]  a_r   [N-1:0];
  logic signed [WIDTH-1:0]  b_r   [N-1:0];
  logic signed [2*WIDTH-1:0] mul_p [N-1:0];
  logic [WIDTH-1:0]         calc  [N-1:0];
  logic [CW-1:0]            n_cnt, k_cnt;
  logic signed [ACCW-1:0]   acc, acc_sum, term;
  logic signed [2*WIDTH-1:0] fir_prod;
  logic signed [CW+1:0]     j_s;
  logic                     j_ok, fir_last_tap, fir_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = (op_t'(bus.operation) == OP_FIR) ? FIR : CALC;
      CALC: state_nx = IDLE;
      FIR:  if (fir_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Element-wise results for the single-cycle ops
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      mul_p[i] = (2*WIDTH)'(a_r[i]) * (2*WIDTH)'(b_r[i]);
      calc[i]  = '0;
      unique case (op_r)
        OP_ADD:  calc[i] = a_r[i] + b_r[i];
        OP_SUB:  calc[i] = a_r[i] - b_r[i];
        OP_MUL:  calc[i] = mul_p[i][FRAC+WIDTH-1:FRAC];
        default: calc[i] = '0;
      endcase
    end
  end

  // FIR tap: sample index j = n + N/2 - k, zero outside [0, N-1].
  // The in-range test on the top two bits relies on N being a power of two.
  always_comb begin
    j_s          = $signed({2'b00, n_cnt}) + HALF - $signed({2'b00, k_cnt});
    j_ok         = (j_s[CW+1:CW] == 2'b00);
    fir_prod     = (2*WIDTH)'(a_r[k_cnt]) * (2*WIDTH)'(b_r[j_s[CW-1:0]]);
    term         = j_ok ? ACCW'(fir_prod) : '0;
    acc_sum      = acc + term;
    fir_last_tap = (k_cnt == CW'(N-1));
    fir_last     = fir_last_tap && (n_cnt == CW'(N-1));
  end

  // Operand latching, accumulation and result/done updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.done <= 1'b0;
      op_r     <= OP_ADD;
      n_cnt    <= '0;
      k_cnt    <= '0;
      acc      <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        bus.result[i] <= '0;
        a_r[i]        <= '0;
        b_r[i]        <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          bus.done <= 1'b0;
          op_r     <= op_t'(bus.operation);
          n_cnt    <= '0;
          k_cnt    <= '0;
          acc      <= '0;
          for (int unsigned i = 0; i < N; i++) begin
            a_r[i] <= bus.A[i];
            b_r[i] <= bus.B[i];
          end
        end
        CALC: begin
          for (int unsigned i = 0; i < N; i++) bus.result[i] <= calc[i];
          bus.done <= 1'b1;
        end
        FIR: begin
          if (fir_last_tap) begin
            bus.result[n_cnt] <= acc_sum[FRAC+WIDTH-1:FRAC];
            acc   <= '0;
            k_cnt <= '0;
            n_cnt <= n_cnt + 1'b1;
            if (fir_last) bus.done <= 1'b1;
          end else begin
            acc   <= acc_sum;
            k_cnt <= k_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_vector_unit.sv
// Directed bench for dsp_vector_unit with hand-computed expected vectors.
module tb_dsp_vector_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  logic [31:0] exp_add [8] = '{32'h30000, 32'h70000, 32'hB0000, 32'hF0000,
                               32'h130000, 32'h170000, 32'h1B0000, 32'h1F0000};
  logic [31:0] exp_mul [8] = '{32'h20000, 32'hC0000, 32'h1E0000, 32'h380000,
                               32'h5A0000, 32'h840000, 32'hB60000, 32'hF00000};
  logic [31:0] exp_sub [8] = '{32'h10000, 32'h10000, 32'h10000, 32'h10000,
                               32'h10000, 32'h10000, 32'h10000, 32'h10000};
  logic [31:0] exp_fir [8] = '{32'h6E0000, 32'hB60000, 32'h1180000, 32'h1980000,
                               32'h2060000, 32'h24E0000, 32'h26C0000, 32'h25C0000};
  logic [31:0] exp_zero [8] = '{default: 32'h0};

  always #5 clk = ~clk;

  dsp_vector_unit_if #(.N(8), .WIDTH(32)) bus ();

  dsp_vector_unit #(.N(8), .WIDTH(32), .FRAC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] e [8]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s[%0d]", tag, i), bus.result[i], e[i]);
  endtask

  // A[i]=(2i+1)<<16, B[i]=(2i+2)<<16, or swapped for subtract
  task automatic set_vec(input bit swap);
    for (int i = 0; i < 8; i++) begin
      bus.A[i] = swap ? 32'((2*i+2) << 16) : 32'((2*i+1) << 16);
      bus.B[i] = swap ? 32'((2*i+1) << 16) : 32'((2*i+2) << 16);
    end
  endtask

  // Pulse start, confirm done cleared by the start edge, count edges to done
  task automatic run_op(input logic [1:0] op, input string tag, output int n);
    @(negedge clk);
    bus.operation = op;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    chk({tag, "_done_clr"}, 32'(bus.done), 32'h0);
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.operation = 2'b00;
    set_vec(1'b0);

    #12;
    chk("rst_done", 32'(bus.done), 32'h0);
    chk_res("rst_res", exp_zero);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, "add", cyc);
    chk("add_lat", 32'(cyc), 32'd2);
    chk_res("add", exp_add);

    run_op(2'b01, "mul", cyc);
    chk("mul_lat", 32'(cyc), 32'd2);
    chk_res("mul", exp_mul);

    set_vec(1'b1);
    run_op(2'b11, "sub", cyc);
    chk_res("sub", exp_sub);

    set_vec(1'b0);
    run_op(2'b10, "fir", cyc);
    chk("fir_lat", 32'(cyc), 32'd65);
    chk_res("fir", exp_fir);

    // Re-run FIR with operand changes and a stray start while busy
    set_vec(1'b1);
    run_op(2'b00, "pre", cyc);
    set_vec(1'b0);
    @(negedge clk);
    bus.operation = 2'b10;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        for (int i = 0; i < 8; i++) begin
          bus.A[i] = 32'h7FFF0000;
          bus.B[i] = 32'h00030000;
        end
        bus.operation = 2'b00;
        bus.start     = 1'b1;
      end else if (cyc == 11) begin
        bus.start = 1'b0;
      end
    end
    chk("busy_lat", 32'(cyc), 32'd65);
    chk_res("busy_fir", exp_fir);

    // Reset in the middle of a FIR run
    set_vec(1'b0);
    @(negedge clk);
    bus.operation = 2'b10;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_done", 32'(bus.done), 32'h0);
    chk_res("midrst_res", exp_zero);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_done", 32'(bus.done), 32'h0);

    run_op(2'b00, "add2", cyc);
    chk("add2_lat", 32'(cyc), 32'd2);
    chk_res("add2", exp_add);

    // Signed Q16.16 multiply: -1.0 * 2.0
    bus.A[0] = 32'hFFFF0000;
    bus.B[0] = 32'h00020000;
    run_op(2'b01, "smul", cyc);
    chk("smul0", bus.result[0], 32'hFFFE0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_vector_unit.md
Name: dsp_vector_unit

Overview:
- Fixed-point (signed Q16.16) vector coprocessor.
- Operates on two 8-element operand vectors A and B.
- Performs element-wise add, multiply or subtract, or an 8-tap FIR (convolution) window.
- Start/done handshake; results held in an 8-entry result register until the next operation.

Parameters:
- N, 8, vector length / FIR tap count (the test plan values use N=8).
- WIDTH, 32, element width in bits.
- FRAC, 16, fractional bits of the fixed-point format.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin an operation.
- operation  in  2  00 add, 01 multiply, 10 FIR, 11 subtract.
- A  in  N x WIDTH  unpacked array A[N-1:0]: operand A / FIR coefficients h.
- B  in  N x WIDTH  unpacked array B[N-1:0]: operand B / FIR signal samples x.
- result  out  N x WIDTH  unpacked array result[N-1:0]: registered results.
- done  out  1  high when result holds the completed operation.

Behaviour:
- Reset (async): state IDLE, all result[i]=0, done=0, counters and accumulator cleared.
- Reset asserted mid-operation aborts the operation immediately. done stays 0.
- States: IDLE, CALC, FIR.
- IDLE, rising edge with start=1:
  - Latch A, B and operation into internal registers; later input changes are ignored.
  - Clear done.
  - Go to CALC for element-wise ops, FIR for op 10.
- start while in CALC or FIR is ignored.
- done stays high after completion until the next accepted start clears it on that same edge. A bench can therefore pulse start and then wait for done rising.
- CALC (one cycle): on the next edge write all N results, set done=1, return to IDLE. The ops are:
  - 00: result[i] = A[i]+B[i].
  - 11: result[i] = A[i]-B[i].
  - 01: result[i] = bits [FRAC+WIDTH-1:FRAC] of the signed 2*WIDTH-bit product A[i]*B[i] (Q16.16 multiply, truncating).
- Add and subtract wrap modulo 2^32; no saturation, no overflow flag.
- FIR: one multiply-accumulate per cycle, output index n=0..N-1 outer loop, tap k=0..N-1 inner loop.
  - Sample index j = n + N/2 - k.
  - Term = A[k]*B[j] (signed, full 2*WIDTH bits) if 0<=j<=N-1, else 0 (zero padding outside the window).
  - Accumulate terms in a 2*WIDTH+4-bit signed accumulator.
  - After the last tap of output n: result[n] = acc[FRAC+WIDTH-1:FRAC]; clear acc.
  - After n=N-1: set done=1, return to IDLE.
- FIR is equivalent to full convolution sample y[n+N/2] for n=0..N-1.
- FIR latency: N*N = 64 cycles in FIR state. Entries not yet written keep their previous values during FIR.
- result entries change only on completion writes or reset.
- Unused op encodings: none, all four are defined.

Test Plan:
- Add: A[i]=(2i+1)<<16, B[i]=(2i+2)<<16, op 00, pulse start.
  - done rises after 2 edges.
  - result = 0x30000, 0x70000, 0xB0000, 0xF0000, 0x130000, 0x170000, 0x1B0000, 0x1F0000.
- Multiply: same vectors, op 01.
  - result = 0x20000, 0xC0000, 0x1E0000, 0x380000, 0x5A0000, 0x840000, 0xB60000, 0xF00000.
  - done was low after the start edge.
- Subtract: A[i]=(2i+2)<<16, B[i]=(2i+1)<<16, op 11 -> every result[i]=0x10000.
- FIR: vectors as in the add test, op 10.
  - done after 64 FIR cycles.
  - result = 0x6E0000, 0xB60000, 0x1180000, 0x1980000, 0x2060000, 0x24E0000, 0x26C0000, 0x25C0000.
- Handshake: change A/B and raise start while FIR is busy -> both ignored, FIR results unchanged.
- Reset: assert rst mid-FIR -> result all 0 and done 0 immediately. After release, op 00 with the first vectors -> 0x30000... as in the add test.
- Signed check: A[0]=0xFFFF0000 (-1.0), B[0]=0x20000, op 01 -> result[0]=0xFFFE0000.
